morse_play_queue: RTL and testbench

Buffers Morse symbols produced in Mode 0 (keypad → encoder) and plays them back-to-back through `buzzer_driver`, so characters confirmed while the buzzer is still sounding are not dropped. It sits between the `morse_encoder` output and the `start`/`morse_code`/`morse_len` inputs of `buzzer_driver`. It inserts standard inter-letter and inter-word silences, timed in 5 Hz Morse units.

---
 rtl/morse_play_queue.sv | 242 ++++++++++++++++++++++++
 tb/tb_morse_play_queue.sv | 409 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/morse_play_queue.sv
// morse_play_queue
// Buffers Morse symbols from the encoder and plays them back-to-back through
// buzzer_driver, inserting inter-letter and inter-word silences. Silences are
// timed in Morse units, one unit per rising edge of the (asynchronous) 5 Hz
// clock.
//
// Ports:
//   clk, rst           system clock, asynchronous active-low reset
//   clk_5hz            5 Hz unit clock (asynchronous, synchronized here)
//   enable             1 = new entries may be popped for playback
//   flush              synchronous clear of all queued entries
//   push, push_code,   write strobe and entry; push_len = 0 marks a word gap
//   push_len
//   busy_in            busy from buzzer_driver
//   start              one-cycle pulse to buzzer_driver
//   morse_code/len     entry being played, held until the next pop
//   count/full/empty   queue occupancy
//   overflow           sticky dropped-push flag, cleared by reset or flush
//   active             playback FSM is not idle
module morse_play_queue #(
  parameter int unsigned DEPTH        = 16,
  parameter int unsigned LETTER_GAP   = 2,
  parameter int unsigned WORD_GAP     = 6,
  parameter int unsigned BUSY_TIMEOUT = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clk_5hz,
  input  logic                     enable,
  input  logic                     flush,
  input  logic                     push,
  input  logic [4:0]               push_code,
  input  logic [2:0]               push_len,
  input  logic                     busy_in,
  output logic                     start,
  output logic [4:0]               morse_code,
  output logic [2:0]               morse_len,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic                     overflow,
  output logic                     active
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam int unsigned ToW  = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;

  localparam logic [CntW-1:0] CntFull   = CntW'(DEPTH);
  localparam logic [ToW-1:0]  ToLast    = ToW'(BUSY_TIMEOUT - 1);
  localparam logic [3:0]      LetterGap = 4'(LETTER_GAP);
  localparam logic [3:0]      WordGap   = 4'(WORD_GAP);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StWaitBusy,
    StWaitDone,
    StGap
  } state_e;

  // ---------------------------------------------------------------------------
  // Unit tick: 2-flop synchronizer plus one flop for rising-edge detection
  // ---------------------------------------------------------------------------
  logic sync1_q, sync2_q, sync3_q;
  logic tick;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      sync3_q <= 1'b0;
    end else begin
      sync1_q <= clk_5hz;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
    end
  end

  assign tick = sync2_q & ~sync3_q;

  // ---------------------------------------------------------------------------
  // Circular buffer of {len, code} entries
  // ---------------------------------------------------------------------------
  logic [7:0]      mem_q [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            full_q, empty_q;
  logic            overflow_q, overflow_d;
  logic            push_ok;
  logic            pop;
  logic [7:0]      head;

  state_e          state_q, state_d;

  // Full is judged on the registered flag, so a pop in the same cycle does
  // not make room for a push that arrives while full.
  assign push_ok = push & ~full_q & ~flush;
  assign pop     = (state_q == StIdle) & enable & ~empty_q & ~busy_in;
  assign head    = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= {push_len, push_code};
    end
  end

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (flush) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      overflow_d = 1'b0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (pop)     rd_ptr_d = rd_ptr_q + PtrW'(1);
      if (push_ok && !pop) begin
        count_d = count_q + CntW'(1);
      end else if (!push_ok && pop) begin
        count_d = count_q - CntW'(1);
      end
      if (push && full_q) overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      full_q     <= (count_d == CntFull);
      empty_q    <= (count_d == '0);
      overflow_q <= overflow_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Playback FSM
  // ---------------------------------------------------------------------------
  logic [3:0]     gap_q, gap_d;
  logic [ToW-1:0] to_q, to_d;
  logic [4:0]     code_q, code_d;
  logic [2:0]     len_q, len_d;
  logic           start_q;
  logic           active_q;

  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    to_d    = to_q;
    code_d  = code_q;
    len_d   = len_q;
    case (state_q)
      StIdle: begin
        if (pop) begin
          code_d = head[4:0];
          len_d  = head[7:5];
          if (head[7:5] != 3'd0) begin
            state_d = StStart;
          end else begin
            gap_d   = WordGap;
            state_d = StGap;
          end
        end
      end
      StStart: begin
        to_d    = '0;
        state_d = StWaitBusy;
      end
      StWaitBusy: begin
        if (busy_in) begin
          state_d = StWaitDone;
        end else if (to_q == ToLast) begin
          // Driver never acknowledged the start; give up rather than deadlock.
          gap_d   = LetterGap;
          state_d = StGap;
        end else begin
          to_d = to_q + ToW'(1);
        end
      end
      StWaitDone: begin
        if (!busy_in) begin
          gap_d   = LetterGap;
          state_d = StGap;
        end
      end
      StGap: begin
        if (tick) begin
          if (gap_q == 4'd1) begin
            state_d = StIdle;
          end else begin
            gap_d = gap_q - 4'd1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      gap_q    <= '0;
      to_q     <= '0;
      code_q   <= '0;
      len_q    <= '0;
      start_q  <= 1'b0;
      active_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      gap_q    <= gap_d;
      to_q     <= to_d;
      code_q   <= code_d;
      len_q    <= len_d;
      // Registered pulse: high for the one cycle after the FSM sat in START.
      start_q  <= (state_q == StStart);
      active_q <= (state_d != StIdle);
    end
  end

  assign start      = start_q;
  assign morse_code = code_q;
  assign morse_len  = len_q;
  assign count      = count_q;
  assign full       = full_q;
  assign empty      = empty_q;
  assign overflow   = overflow_q;
  assign active     = active_q;

endmodule

// File: tb/tb_morse_play_queue.sv
// Directed bench for morse_play_queue. One Morse unit is shortened to 40 clk
// cycles so gaps are observable in a short run. A buzzer_driver model raises
// busy_in for busy_len cycles after each start when drv_en is set.
module tb_morse_play_queue;

  localparam int Unit = 40;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       clk_5hz = 1'b0;
  logic       enable = 1'b1;
  logic       flush = 1'b0;
  logic       push = 1'b0;
  logic [4:0] push_code = '0;
  logic [2:0] push_len = '0;
  logic       busy_in;
  logic       start;
  logic [4:0] morse_code;
  logic [2:0] morse_len;
  logic [4:0] count;
  logic       full, empty, overflow, active;

  int checks = 0;
  int failures = 0;

  morse_play_queue #(
    .DEPTH(16), .LETTER_GAP(2), .WORD_GAP(6), .BUSY_TIMEOUT(8)
  ) dut (
    .clk(clk), .rst(rst), .clk_5hz(clk_5hz), .enable(enable), .flush(flush),
    .push(push), .push_code(push_code), .push_len(push_len), .busy_in(busy_in),
    .start(start), .morse_code(morse_code), .morse_len(morse_len), .count(count),
    .full(full), .empty(empty), .overflow(overflow), .active(active)
  );

  always #5 clk = ~clk;
  always #(Unit * 5) clk_5hz = ~clk_5hz;

  // Driver model and start monitor, evaluated 1 time unit after each edge.
  logic       drv_en = 1'b1;
  int         busy_len = 600;
  int         busy_left = 0;
  int         cyc = 0;
  int         last_fall = 0;
  int         n_log = 0;
  int         dbl_cnt = 0;
  logic       prev_start = 1'b0;
  logic [4:0] log_code [64];
  logic [2:0] log_len [64];
  int         start_cyc [64];
  int         fall_before [64];

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_left  = 0;
      busy_in    = 1'b0;
      prev_start = 1'b0;
    end else begin
      #1;
      cyc++;
      if (start) begin
        if (prev_start) dbl_cnt++;
        if (n_log < 64) begin
          log_code[n_log]    = morse_code;
          log_len[n_log]     = morse_len;
          start_cyc[n_log]   = cyc;
          fall_before[n_log] = last_fall;
        end
        n_log++;
        if (drv_en) busy_left = busy_len;
      end
      prev_start = start;
      if (busy_left > 0) begin
        busy_left--;
        busy_in = 1'b1;
      end else begin
        if (busy_in) last_fall = cyc;
        busy_in = 1'b0;
      end
    end
  end

  task automatic do_push(input logic [2:0] len, input logic [4:0] code);
    @(negedge clk);
    push = 1'b1; push_len = len; push_code = code;
    @(negedge clk);
    push = 1'b0;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_idle(input string name, input int bound);
    int k = 0;
    while (k < bound && (active || busy_in || count != 0)) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (active || busy_in || count != 0) begin
      failures++;
      $display("FAIL %s idle timeout: active=%0b busy=%0b count=%0d, want idle", name, active,
               busy_in, count);
    end
  endtask

  task automatic wait_starts(input string name, input int target, input int bound);
    int k = 0;
    while (k < bound && n_log < target) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (n_log < target) begin
      failures++;
      $display("FAIL %s start timeout: starts=%0d want=%0d", name, n_log, target);
    end
  endtask

  task automatic test_reset;
    rst = 1'b0;
    wait_cycles(3);
    checks++;
    if ({start, morse_code, morse_len, count, full, empty, overflow, active} !==
        {1'b0, 5'd0, 3'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL reset_in: got st=%0b code=%0h len=%0d cnt=%0d f=%0b e=%0b o=%0b a=%0b",
               start, morse_code, morse_len, count, full, empty, overflow, active);
    end
    rst = 1'b1;
    wait_cycles(2);
    checks++;
    if ({start, count, empty, active} !== {1'b0, 5'd0, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL reset_out: st=%0b cnt=%0d e=%0b a=%0b, want 0 0 1 0", start, count,
               empty, active);
    end
  endtask

  task automatic test_single;
    int n0 = n_log;
    drv_en = 1'b1; busy_len = 30;
    do_push(3'd1, 5'd0);  // edge N
    checks++;
    if (count !== 5'd1 || empty !== 1'b0) begin
      failures++;
      $display("FAIL e_count_n: count=%0d empty=%0b, want 1 0", count, empty);
    end
    @(negedge clk);  // after N+1: popped
    checks++;
    if (count !== 5'd0 || start !== 1'b0 || active !== 1'b1 || morse_len !== 3'd1) begin
      failures++;
      $display("FAIL e_pop: count=%0d start=%0b active=%0b len=%0d, want 0 0 1 1", count, start,
               active, morse_len);
    end
    @(negedge clk);  // after N+2
    checks++;
    if (start !== 1'b1 || morse_code !== 5'd0 || morse_len !== 3'd1) begin
      failures++;
      $display("FAIL e_start: start=%0b code=%0h len=%0d, want 1 0 1", start, morse_code,
               morse_len);
    end
    @(negedge clk);
    checks++;
    if (start !== 1'b0) begin
      failures++;
      $display("FAIL e_start_width: start=%0b, want 0", start);
    end
    wait_idle("e", 400);
    checks++;
    if (n_log !== n0 + 1) begin
      failures++;
      $display("FAIL e_nstarts: got %0d want %0d", n_log - n0, 1);
    end
  endtask

  task automatic test_back_to_back;
    int n0 = n_log;
    int gap;
    drv_en = 1'b1; busy_len = 600;
    @(negedge clk); push = 1'b1; push_len = 3'd2; push_code = 5'b00010;
    @(negedge clk); push_len = 3'd0; push_code = 5'b00000;
    @(negedge clk); push_len = 3'd4; push_code = 5'b00001;
    @(negedge clk); push = 1'b0;
    wait_starts("seq", n0 + 2, 3000);
    wait_idle("seq", 3000);
    checks++;
    if (n_log !== n0 + 2) begin
      failures++;
      $display("FAIL seq_nstarts: got %0d want 2", n_log - n0);
    end
    checks++;
    if ({log_len[n0], log_code[n0]} !== {3'd2, 5'b00010}) begin
      failures++;
      $display("FAIL seq_a: got len=%0d code=%b want 2 00010", log_len[n0], log_code[n0]);
    end
    checks++;
    if ({log_len[n0+1], log_code[n0+1]} !== {3'd4, 5'b00001}) begin
      failures++;
      $display("FAIL seq_b: got len=%0d code=%b want 4 00001", log_len[n0+1], log_code[n0+1]);
    end
    checks++;
    if (morse_code !== 5'b00001) begin
      failures++;
      $display("FAIL seq_hold: morse_code=%b want 00001", morse_code);
    end
    // Letter gap 2 plus word gap 6, each with up to one unit of tick phase.
    gap = start_cyc[n0+1] - fall_before[n0+1];
    checks++;
    if (gap < 7 * Unit - 10 || gap > 9 * Unit + 10) begin
      failures++;
      $display("FAIL seq_gap: got %0d cycles want %0d..%0d", gap, 7 * Unit - 10, 9 * Unit + 10);
    end
  endtask

  task automatic test_full_wrap;
    int n0 = n_log;
    drv_en = 1'b1; busy_len = 20;
    enable = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      push = 1'b1; push_len = 3'((i % 5) + 1); push_code = 5'(i + 3);
    end
    @(negedge clk); push = 1'b0;
    checks++;
    if (full !== 1'b1 || count !== 5'd16 || overflow !== 1'b0) begin
      failures++;
      $display("FAIL full16: full=%0b count=%0d ovf=%0b want 1 16 0", full, count, overflow);
    end
    do_push(3'd5, 5'h1f);  // 17th push is dropped
    checks++;
    if (full !== 1'b1 || count !== 5'd16 || overflow !== 1'b1 || active !== 1'b0 ||
        n_log !== n0) begin
      failures++;
      $display("FAIL full17: full=%0b count=%0d ovf=%0b active=%0b starts=%0d want 1 16 1 0 0",
               full, count, overflow, active, n_log - n0);
    end
    enable = 1'b1;
    wait_starts("drain", n0 + 16, 4000);
    wait_idle("drain", 400);
    for (int i = 0; i < 16; i++) begin
      checks++;
      if ({log_len[n0+i], log_code[n0+i]} !== {3'((i % 5) + 1), 5'(i + 3)}) begin
        failures++;
        $display("FAIL drain_%0d: got len=%0d code=%0h want len=%0d code=%0h", i,
                 log_len[n0+i], log_code[n0+i], (i % 5) + 1, i + 3);
      end
    end
    checks++;
    if (n_log !== n0 + 16 || overflow !== 1'b1 || empty !== 1'b1) begin
      failures++;
      $display("FAIL drain_end: starts=%0d ovf=%0b empty=%0b want 16 1 1", n_log - n0,
               overflow, empty);
    end
  endtask

  task automatic test_timeout;
    int n0 = n_log;
    int k = 0;
    drv_en = 1'b0;
    do_push(3'd3, 5'b00101);
    wait_starts("to", n0 + 1, 20);
    wait_cycles(12);
    checks++;
    if (active !== 1'b1) begin
      failures++;
      $display("FAIL to_gap_active: active=%0b want 1", active);
    end
    while (k < 200 && active) begin
      @(negedge clk);
      k++;
    end
    // WAIT_BUSY 8 cycles, then a letter gap of 1..2 units.
    checks++;
    if (active || (cyc - start_cyc[n0]) < 45 || (cyc - start_cyc[n0]) > 95) begin
      failures++;
      $display("FAIL to_release: active=%0b after %0d cycles, want 0 within 45..95", active,
               cyc - start_cyc[n0]);
    end
    drv_en = 1'b1;
  endtask

  task automatic test_flush;
    int n0 = n_log;
    int k = 0;
    drv_en = 1'b1; busy_len = 300;
    do_push(3'd1, 5'b00001);
    do_push(3'd2, 5'b00011);
    do_push(3'd3, 5'b00111);
    wait_starts("fl", n0 + 1, 20);
    wait_cycles(10);
    checks++;
    if (count !== 5'd2 || overflow !== 1'b1) begin
      failures++;
      $display("FAIL fl_pre: count=%0d ovf=%0b want 2 1", count, overflow);
    end
    @(negedge clk);
    flush = 1'b1; push = 1'b1; push_len = 3'd4; push_code = 5'b01111;
    @(negedge clk);
    flush = 1'b0; push = 1'b0;
    checks++;
    if (count !== 5'd0 || overflow !== 1'b0 || empty !== 1'b1 || active !== 1'b1 ||
        busy_in !== 1'b1) begin
      failures++;
      $display("FAIL fl_post: count=%0d ovf=%0b empty=%0b active=%0b busy=%0b want 0 0 1 1 1",
               count, overflow, empty, active, busy_in);
    end
    while (k < 400 && busy_in) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (busy_in !== 1'b0 || active !== 1'b1) begin
      failures++;
      $display("FAIL fl_gap: busy=%0b active=%0b want 0 1", busy_in, active);
    end
    wait_idle("fl", 200);
    wait_cycles(200);
    checks++;
    if (n_log !== n0 + 1 || log_code[n0] !== 5'b00001) begin
      failures++;
      $display("FAIL fl_starts: starts=%0d code=%b want 1 00001", n_log - n0, log_code[n0]);
    end
  endtask

  task automatic test_async_reset;
    int n0 = n_log;
    int k = 0;
    drv_en = 1'b1; busy_len = 300;
    do_push(3'd2, 5'b00011);
    do_push(3'd2, 5'b00001);
    wait_starts("rd", n0 + 1, 20);
    wait_cycles(20);  // WAIT_DONE, one entry still queued
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({start, morse_code, morse_len, count, full, empty, overflow, active} !==
        {1'b0, 5'd0, 3'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL rst_wait_done: st=%0b code=%0h len=%0d cnt=%0d e=%0b a=%0b want reset",
               start, morse_code, morse_len, count, empty, active);
    end
    @(negedge clk); rst = 1'b1;
    wait_cycles(300);
    checks++;
    if (n_log !== n0 + 1 || active !== 1'b0) begin
      failures++;
      $display("FAIL rst_quiet1: starts=%0d active=%0b want 1 0", n_log - n0, active);
    end
    busy_len = 20;
    do_push(3'd3, 5'b00010);
    wait_starts("rg", n0 + 2, 20);
    while (k < 100 && busy_in) begin
      @(negedge clk);
      k++;
    end
    wait_cycles(5);
    checks++;
    if (active !== 1'b1 || busy_in !== 1'b0) begin
      failures++;
      $display("FAIL rst_in_gap: active=%0b busy=%0b want 1 0", active, busy_in);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({start, morse_code, morse_len, count, active} !== {1'b0, 5'd0, 3'd0, 5'd0, 1'b0}) begin
      failures++;
      $display("FAIL rst_gap: st=%0b code=%0h len=%0d cnt=%0d a=%0b want all 0", start,
               morse_code, morse_len, count, active);
    end
    @(negedge clk); rst = 1'b1;
    wait_cycles(200);
    checks++;
    if (n_log !== n0 + 2) begin
      failures++;
      $display("FAIL rst_quiet2: starts=%0d want 2", n_log - n0);
    end
    do_push(3'd1, 5'd0);
    wait_starts("rnew", n0 + 3, 20);
    checks++;
    if (log_len[n0+2] !== 3'd1) begin
      failures++;
      $display("FAIL rst_new: len=%0d want 1", log_len[n0+2]);
    end
    wait_idle("rnew", 300);
  endtask

  task automatic test_pulse_width;
    checks++;
    if (dbl_cnt !== 0) begin
      failures++;
      $display("FAIL start_width: %0d multi-cycle pulses, want 0", dbl_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_full_wrap();
    test_timeout();
    test_flush();
    test_async_reset();
    test_pulse_width();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
